// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types and encodings for the CPU control path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [3:0] {
        S_WAIT      = 4'd0,
        S_DECODE    = 4'd1,
        S_WRITE_IMM = 4'd2,
        S_GET_A     = 4'd3,
        S_GET_B     = 4'd4,
        S_EXEC      = 4'd5,
        S_CMP_S     = 4'd6,
        S_WRITE_RD  = 4'd7,
        S_ILLEGAL   = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CLS_MOV_IMM = 3'd0,
        CLS_MOV_REG = 3'd1,
        CLS_ADD     = 3'd2,
        CLS_CMP     = 3'd3,
        CLS_AND     = 3'd4,
        CLS_MVN     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_cls_e;

    localparam logic [2:0] OPC_MOV   = 3'b110;
    localparam logic [2:0] OPC_ALU   = 3'b101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_AND   = 2'b10;
    localparam logic [1:0] ALU_MVN   = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_fsm_instr_class_dec.sv
// ============================================================================
// Module   : instr_class_dec
// Purpose  : Combinational {opcode, op} to instruction-class decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_class_dec
    import cpu_pkg::*;
(
    input  logic [2:0] i_opcode,
    input  logic [1:0] i_op,
    output instr_cls_e o_cls,
    output logic       o_legal
);

    always_comb begin
        o_cls   = CLS_ILLEGAL;
        o_legal = 1'b0;
        case ({i_opcode, i_op})
            {OPC_MOV, 2'b10}:   begin o_cls = CLS_MOV_IMM; o_legal = 1'b1; end
            {OPC_MOV, 2'b00}:   begin o_cls = CLS_MOV_REG; o_legal = 1'b1; end
            {OPC_ALU, ALU_ADD}: begin o_cls = CLS_ADD;     o_legal = 1'b1; end
            {OPC_ALU, ALU_CMP}: begin o_cls = CLS_CMP;     o_legal = 1'b1; end
            {OPC_ALU, ALU_AND}: begin o_cls = CLS_AND;     o_legal = 1'b1; end
            {OPC_ALU, ALU_MVN}: begin o_cls = CLS_MVN;     o_legal = 1'b1; end
            default:            begin o_cls = CLS_ILLEGAL; o_legal = 1'b0; end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer_fsm.sv
// ============================================================================
// Module   : alu_sequencer_fsm
// Purpose  : Moore control FSM sequencing the register-file/ALU datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer_fsm
    import cpu_pkg::*;
#(
    parameter int STATE_W = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] ALUop,
    output logic       illegal
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic [2:0]         r_opcode;
    logic [1:0]         r_op;
    instr_cls_e         w_cls;
    logic               w_legal;

    // Decode works on the latched instruction so mid-flight input changes are ignored.
    instr_class_dec u_dec (
        .i_opcode (r_opcode),
        .i_op     (r_op),
        .o_cls    (w_cls),
        .o_legal  (w_legal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= STATE_W'(S_WAIT);
            r_opcode <= 3'b000;
            r_op     <= 2'b00;
        end else begin
            r_state <= w_state_next;
            if (r_state == STATE_W'(S_WAIT) && s) begin
                r_opcode <= opcode;
                r_op     <= op;
            end
        end
    end

    always_comb begin
        w_state_next = STATE_W'(S_WAIT);
        w            = 1'b0;
        nsel         = NSEL_NONE;
        vsel         = VSEL_C;
        write        = 1'b0;
        loada        = 1'b0;
        loadb        = 1'b0;
        loadc        = 1'b0;
        loads        = 1'b0;
        asel         = 1'b0;
        bsel         = 1'b0;
        ALUop        = ALU_ADD;
        illegal      = 1'b0;

        case (r_state)
            STATE_W'(S_WAIT): begin
                w            = 1'b1;
                w_state_next = s ? STATE_W'(S_DECODE) : STATE_W'(S_WAIT);
            end
            STATE_W'(S_DECODE): begin
                if (!w_legal) begin
                    w_state_next = STATE_W'(S_ILLEGAL);
                end else begin
                    case (w_cls)
                        CLS_MOV_IMM: w_state_next = STATE_W'(S_WRITE_IMM);
                        CLS_MOV_REG: w_state_next = STATE_W'(S_GET_B);
                        CLS_MVN:     w_state_next = STATE_W'(S_GET_B);
                        CLS_ADD,
                        CLS_CMP,
                        CLS_AND:     w_state_next = STATE_W'(S_GET_A);
                        default:     w_state_next = STATE_W'(S_ILLEGAL);
                    endcase
                end
            end
            STATE_W'(S_WRITE_IMM): begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            STATE_W'(S_GET_A): begin
                nsel         = NSEL_RN;
                loada        = 1'b1;
                w_state_next = STATE_W'(S_GET_B);
            end
            STATE_W'(S_GET_B): begin
                nsel         = NSEL_RM;
                loadb        = 1'b1;
                w_state_next = (w_cls == CLS_CMP) ? STATE_W'(S_CMP_S) : STATE_W'(S_EXEC);
            end
            STATE_W'(S_EXEC): begin
                loadc        = 1'b1;
                w_state_next = STATE_W'(S_WRITE_RD);
                case (w_cls)
                    CLS_MOV_REG: begin ALUop = ALU_ADD; asel = 1'b1; end
                    CLS_MVN:     ALUop = ALU_MVN;
                    default:     ALUop = r_op;
                endcase
            end
            // Compare only updates status; C stays untouched since ALU out is undefined here.
            STATE_W'(S_CMP_S): begin
                ALUop = ALU_CMP;
                loads = 1'b1;
            end
            STATE_W'(S_WRITE_RD): begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            STATE_W'(S_ILLEGAL): begin
                illegal = 1'b1;
            end
            default: begin
                w = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/alu_sequencer_fsm.md
Name: alu_sequencer_fsm

Overview:
- Moore control FSM that sequences the register-file/ALU datapath, one instruction per start pulse.
- Inputs are the instruction's opcode/op fields and a start strobe. Outputs are per-cycle datapath enables, register-select, writeback-select and ALUop.
- Sits between the instruction register and the datapath.
- Guarantees the ALU result register is never loaded during a compare, because ALU out is undefined for ALUop=01.

Parameters:
- STATE_W, 4, width of the encoded state register (must hold 9 states).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- s  in  1  start strobe; sampled only in WAIT
- opcode  in  3  instruction opcode (110 = MOV class, 101 = ALU class)
- op  in  2  sub-op; for ALU class it is passed through as ALUop
- w  out  1  1 = idle/ready (WAIT state)
- nsel  out  3  one-hot register select: 001 = Rn, 010 = Rd, 100 = Rm, 000 = none
- vsel  out  2  writeback source: 00 = C (ALU result), 10 = sign-extended imm8
- write  out  1  register-file write enable
- loada  out  1  load A register
- loadb  out  1  load B register
- loadc  out  1  load C (result) register
- loads  out  1  load status register
- asel  out  1  1 = ALU A input forced to 0
- bsel  out  1  0 = shifted B (datapath); 1 = imm5
- ALUop  out  2  ALU operation
- illegal  out  1  one-cycle pulse on an undefined opcode/op

Behaviour:
- All outputs are decoded from the current state only (Moore). No input-to-output combinational path.
- Reset: when reset==0 at a clk edge, next state is WAIT. This holds in any state, mid-instruction included.
- In WAIT: w=1; all other outputs 0; nsel=000; vsel=00; ALUop=00.
- Instruction latch: in WAIT with s=1, opcode/op are captured into internal registers and the FSM moves to DECODE. Later changes on opcode/op are ignored until the next WAIT.
- In WAIT with s=0, the FSM stays in WAIT. s is ignored in every other state.
- DECODE: all controls 0; w=0. Next state by latched {opcode, op}:
  - 110/10 MOV imm -> WRITE_IMM
  - 110/00 MOV reg -> GET_B
  - 101/00 ADD, 101/01 CMP, 101/10 AND -> GET_A
  - 101/11 MVN -> GET_B
  - anything else -> ILLEGAL
- WRITE_IMM: nsel=001, vsel=10, write=1 -> WAIT.
- GET_A: nsel=001, loada=1 -> GET_B.
- GET_B: nsel=100, loadb=1. Next is CMP_S if CMP, else EXEC.
- EXEC: loadc=1; bsel=0; ALUop and asel per instruction:
  - MOV reg: ALUop=00, asel=1 (result = 0 + B).
  - ADD/AND: ALUop=op, asel=0.
  - MVN: ALUop=11, asel=0.
  - Then -> WRITE_RD.
- CMP_S: ALUop=01, asel=0, loads=1, loadc=0 -> WAIT.
- WRITE_RD: nsel=010, vsel=00, write=1 -> WAIT.
- ILLEGAL: illegal=1 for exactly this cycle; no write, no load -> WAIT.
- Latency, counted in clk edges from the s-sampling edge to w=1:
  - MOV imm: 3
  - MOV reg: 5
  - ADD/AND: 6
  - MVN: 5
  - CMP: 5
  - illegal: 3
- Invariants, always true:
  - At most one of write, loada, loadb, loadc, loads is asserted per cycle.
  - write=1 implies nsel≠000.
  - loadc=1 never coincides with ALUop=01.
- s held high continuously: a new instruction starts on the first clk edge in WAIT, i.e. back-to-back with no extra idle cycle beyond the single WAIT cycle.
- Unreachable state encodings go to WAIT on the next edge, with outputs as in WAIT.

Decomposition:
- Shared package cpu_pkg:
  - state enum (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, CMP_S, WRITE_RD, ILLEGAL)
  - opcode constants OPC_MOV=3'b110, OPC_ALU=3'b101
  - ALUop constants ADD/CMP/AND/MVN
  - nsel constants NSEL_RN/RD/RM
  - vsel constants VSEL_C/VSEL_IMM
- Sub-module instr_class_dec: combinational; {opcode, op} -> instruction-class enum plus legal flag. Reused later by the instruction-fetch FSM.

Test Plan:
- Reset low for 2 cycles from an arbitrary state, then high -> w=1, all controls 0 on the first edge after reset is asserted.
- MOV imm (opcode=110, op=10, s=1 for one cycle) -> cycle 2 shows nsel=001, vsel=10, write=1; w=1 at edge 3; exactly one write pulse.
- ADD (101/00) -> ordered pulses:
  - loada with nsel=001
  - loadb with nsel=100
  - loadc with ALUop=00, asel=0
  - write with nsel=010, vsel=00
  - w=1 at edge 6.
- CMP (101/01) -> loada, loadb, then loads=1 with ALUop=01; loadc and write never asserted; w=1 at edge 5.
- Sequence checks:
  - MVN then MOV reg back-to-back with s held high -> ALUop=11 then ALUop=00 with asel=1.
  - opcode changed to 000 during EXEC -> no effect.
- Illegal opcode 111, s=1 -> illegal pulses one cycle, no write/loads, w=1 at edge 3.
- Reset low during EXEC of ADD -> WAIT next edge, write never asserted.
